// File: rtl/micro_uaz_pkg.sv
// Shared MicroUAZ definitions: FSM state encoding and sizing helpers for
// the serial complement-path blocks.
package micro_uaz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cntWidth(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/decodificador_complemento1_sumador_serial_bit.sv
// Registered one-bit half-adder cell: the carry is held in a flop,
// the sum is formed from the incoming bit and the stored carry.
module sumador_serial_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bit,
    input  logic i_carry_load,
    input  logic i_load,
    input  logic i_en,
    output logic o_sum,
    output logic o_carry
);

    logic r_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_carry <= i_carry_load;
        end else if (i_en) begin
            r_carry <= i_bit & r_carry;
        end
    end

    assign o_sum   = i_bit ^ r_carry;
    assign o_carry = r_carry;

endmodule

// File: rtl/decodificador_complemento1.sv
// Bit-serial one's-complement decoder: LSB-first over WIDTH cycles it yields
// the two's-complement value, magnitude, normalised sign and a -0 flag.
module decodificador_complemento1
    import micro_uaz_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] twos_out,
    output logic [WIDTH-1:0] mag_out,
    output logic             sign_out,
    output logic             neg_zero_out
);

    localparam int CW = cntWidth(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_src;
    logic [WIDTH-1:0] r_twos_sh;
    logic [WIDTH-1:0] r_mag_sh;
    logic [WIDTH-1:0] r_twos_out;
    logic [WIDTH-1:0] r_mag_out;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic             r_negz;
    logic             r_sign_out;
    logic             r_negz_out;
    logic             r_in_ready;
    logic             r_out_valid;

    logic w_bit;
    logic w_load;
    logic w_en;
    logic w_sum;
    logic w_carry;
    logic w_mag_bit;

    assign w_bit     = r_src[0];
    assign w_load    = (r_state == IDLE) && in_valid;
    assign w_en      = (r_state == SHIFT);
    assign w_mag_bit = w_bit ^ r_sign;

    // The carry starts at the sign so negative operands get their +1 added serially.
    sumador_serial_bit u_sumador (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_bit        (w_bit),
        .i_carry_load (in_data[WIDTH-1]),
        .i_load       (w_load),
        .i_en         (w_en),
        .o_sum        (w_sum),
        .o_carry      (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_twos_sh   <= '0;
            r_mag_sh    <= '0;
            r_twos_out  <= '0;
            r_mag_out   <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_negz      <= 1'b0;
            r_sign_out  <= 1'b0;
            r_negz_out  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_src      <= in_data;
                        r_sign     <= in_data[WIDTH-1];
                        r_negz     <= (in_data == {WIDTH{1'b1}});
                        r_cnt      <= CW'(WIDTH - 1);
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_twos_sh <= {w_sum, r_twos_sh[WIDTH-1:1]};
                    r_mag_sh  <= {w_mag_bit, r_mag_sh[WIDTH-1:1]};
                    r_src     <= {1'b0, r_src[WIDTH-1:1]};
                    if (r_cnt == '0) begin
                        r_twos_out  <= {w_sum, r_twos_sh[WIDTH-1:1]};
                        r_mag_out   <= {w_mag_bit, r_mag_sh[WIDTH-1:1]};
                        // A carry out of the last bit only happens for -0, whose sign is cleared.
                        r_sign_out  <= r_sign & ~(w_bit & w_carry);
                        r_negz_out  <= r_negz;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign twos_out     = r_twos_out;
    assign mag_out      = r_mag_out;
    assign sign_out     = r_sign_out;
    assign neg_zero_out = r_negz_out;

endmodule

// File: tb/tb_decodificador_complemento1.sv
// Self-checking bench for decodificador_complemento1: directed corner operands,
// backpressure, mid-operation reset and random operands against a signed-value model.
module tb_decodificador_complemento1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] twos_out;
    logic [W-1:0] mag_out;
    logic         sign_out;
    logic         neg_zero_out;

    int testsRun = 0;
    int testsFailed = 0;

    decodificador_complemento1 #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .twos_out     (twos_out),
        .mag_out      (mag_out),
        .sign_out     (sign_out),
        .neg_zero_out (neg_zero_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Interpret the operand as a signed one's-complement number, then re-encode it.
    task automatic refModel(input logic [W-1:0] op, output logic [W-1:0] eTwos,
                            output logic [W-1:0] eMag, output logic eSign, output logic eNegz);
        logic [W-1:0] inv;
        int value;
        inv = ~op;
        value = op[W-1] ? -int'(inv) : int'(op);
        eTwos = W'(value);
        eMag  = W'((value < 0) ? -value : value);
        eSign = (value < 0);
        eNegz = (op == {W{1'b1}});
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] op);
        logic [W-1:0] eT, eM;
        logic eS, eZ;
        refModel(op, eT, eM, eS, eZ);
        checkOutput({tag, "_twos"}, twos_out, eT);
        checkOutput({tag, "_mag"}, mag_out, eM);
        checkOutput({tag, "_sign"}, sign_out, eS);
        checkOutput({tag, "_negz"}, neg_zero_out, eZ);
    endtask

    task automatic applyStimulus(input logic [W-1:0] op, input int hold);
        int n;
        logic [W-1:0] eT, eM;
        logic eS, eZ;
        refModel(op, eT, eM, eS, eZ);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data = op;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = W'($urandom);
        checkOutput("busy", {in_ready, out_valid}, 2'b00);
        waitValid(n);
        checkOutput("latency", n, W);
        checkResult("res", op);
        checkOutput("done_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold", {in_ready, out_valid, twos_out, mag_out, sign_out, neg_zero_out},
                        {1'b0, 1'b1, eT, eM, eS, eZ});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release", {in_ready, out_valid}, 2'b10);
        checkOutput("keep_twos", twos_out, eT);
    endtask

    initial begin
        int n;
        logic [W-1:0] directed [6] = '{8'h05, 8'hFA, 8'hFF, 8'h00, 8'h80, 8'h7F};

        repeat (2) @(negedge clk);
        checkOutput("rst_flags", {in_ready, out_valid}, 2'b10);
        checkOutput("rst_data", {twos_out, mag_out, sign_out, neg_zero_out}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (directed[i]) applyStimulus(directed[i], 1);

        // Backpressure with a new operand waiting on the input.
        in_valid = 1'b1;
        in_data = 8'hFA;
        @(negedge clk);
        in_data = 8'h01;
        waitValid(n);
        checkOutput("bp_latency", n, W);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold", {in_ready, out_valid, twos_out, mag_out, sign_out, neg_zero_out},
                        {1'b0, 1'b1, 8'hFB, 8'h05, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_idle", {in_ready, out_valid}, 2'b10);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_accept", in_ready, 0);
        waitValid(n);
        checkOutput("bp_latency2", n, W);
        checkResult("bp", 8'h01);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset three edges into SHIFT must abort without leaving a result.
        in_valid = 1'b1;
        in_data = 8'hFA;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_flags", {in_ready, out_valid}, 2'b10);
        checkOutput("abort_data", {twos_out, mag_out, sign_out, neg_zero_out}, 0);
        applyStimulus(8'h03, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(W'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
